div: RTL

Multi-cycle 32-bit divider serving the EX stage for DIV/DIVU. EX starts a division, holds its stall request while the divider is busy, and consumes the 64-bit result when `ready_o` rises. The divider performs restoring division, one quotient bit per cycle. It supports signed and unsigned operands, a divide-by-zero shortcut, and annulment on pipeline flush.

---
 rtl/div_pkg.sv | 32 +++
 rtl/div_step.sv | 23 ++
 rtl/div.sv | 104 ++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle restoring divider: bus widths,
// FSM state codes, handshake levels and a two's-complement magnitude helper.
package div_pkg;

   localparam int REG_BUS        = 32;
   localparam int DOUBLE_REG_BUS = 64;

   localparam logic RST_ENABLE = 1'b0;

   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;
   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;

   // Number of quotient bits produced, one per ON cycle.
   localparam logic [5:0] DIV_STEPS = 6'd32;

   typedef enum logic [1:0] {
      DIV_FREE    = 2'b00,
      DIV_BY_ZERO = 2'b01,
      DIV_ON      = 2'b10,
      DIV_END     = 2'b11
   } div_state_t;

   // Conditional two's-complement negation; used both to take operand
   // magnitudes on entry and to restore result signs on exit.
   function automatic logic [REG_BUS-1:0] magnitude(input logic [REG_BUS-1:0] value,
                                                     input logic              negate);
      return negate ? (~value + 32'd1) : value;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial-subtract the divisor from the
// partial remainder and shift in either a 1 (subtract kept) or a 0 (restored).
module div_step
   import div_pkg::*;
(
   input  logic [2*REG_BUS:0]   work,
   input  logic [REG_BUS-1:0]   divisor,
   output logic [2*REG_BUS:0]   work_next
);

   logic [REG_BUS:0] diff;
   logic             take;

   // Trial subtraction; a set bit 64 means the shifted partial remainder
   // already exceeds any 32-bit divisor, so the subtraction must be kept.
   always_comb begin
      diff      = {1'b0, work[63:32]} - {1'b0, divisor};
      take      = !diff[REG_BUS] || work[64];
      work_next = take ? {diff[31:0], work[31:0], 1'b1}
                       : {work[63:0], 1'b0};
   end

endmodule

// File: rtl/div.sv
// Multi-cycle 32-bit signed/unsigned divider for the EX stage. Produces
// {remainder, quotient} 33 cycles after the start is accepted, or one cycle
// after for a zero divisor, and holds it until EX drops start_i.
module div
   import div_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      signed_div_i,
   input  logic [REG_BUS-1:0]        dividend_i,
   input  logic [REG_BUS-1:0]        divisor_i,
   input  logic                      start_i,
   input  logic                      annul_i,
   output logic [DOUBLE_REG_BUS-1:0] result_o,
   output logic                      ready_o
);

   div_state_t                state;
   div_state_t                state_next;
   logic [5:0]                cnt;
   logic [2*REG_BUS:0]        work;
   logic [2*REG_BUS:0]        work_step;
   logic [REG_BUS-1:0]        divisor_r;
   logic                      dividend_neg;
   logic                      quotient_neg;
   logic [DOUBLE_REG_BUS-1:0] result_r;
   logic                      accept;
   logic                      release_end;

   assign accept      = (start_i == DIV_START) && !annul_i;
   assign release_end = (start_i == DIV_STOP) || annul_i;

   div_step u_step (
      .work      (work),
      .divisor   (divisor_r),
      .work_next (work_step)
   );

   // State register, forced to FREE the moment reset goes low.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) state <= DIV_FREE;
      else                   state <= state_next;
   end

   // Next-state logic; annul beats both a new start and the finalising edge.
   always_comb begin
      state_next = state;
      case (state)
         DIV_FREE:    if (accept) state_next = (divisor_i == '0) ? DIV_BY_ZERO : DIV_ON;
         DIV_BY_ZERO: state_next = DIV_END;
         DIV_ON: begin
            if (annul_i)                state_next = DIV_FREE;
            else if (cnt == DIV_STEPS)  state_next = DIV_END;
         end
         DIV_END:     if (release_end) state_next = DIV_FREE;
         default:     state_next = DIV_FREE;
      endcase
   end

   // Operand capture, iteration and sign fix-up of the finished result.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) begin
         cnt          <= '0;
         work         <= '0;
         divisor_r    <= '0;
         dividend_neg <= 1'b0;
         quotient_neg <= 1'b0;
         result_r     <= '0;
      end else begin
         case (state)
            DIV_FREE: begin
               if (accept) begin
                  divisor_r    <= magnitude(divisor_i, signed_div_i & divisor_i[31]);
                  work         <= {32'b0, magnitude(dividend_i, signed_div_i & dividend_i[31]), 1'b0};
                  cnt          <= '0;
                  dividend_neg <= signed_div_i & dividend_i[31];
                  quotient_neg <= signed_div_i & (dividend_i[31] ^ divisor_i[31]);
               end
            end
            DIV_BY_ZERO: result_r <= '0;
            DIV_ON: begin
               if (!annul_i) begin
                  if (cnt == DIV_STEPS) begin
                     result_r <= {magnitude(work[64:33], dividend_neg),
                                  magnitude(work[31:0], quotient_neg)};
                  end else begin
                     work <= work_step;
                     cnt  <= cnt + 6'd1;
                  end
               end
            end
            DIV_END: if (release_end) result_r <= '0;
            default: ;
         endcase
      end
   end

   // Result is only visible while parked in END; zero everywhere else.
   always_comb begin
      ready_o  = (state == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
      result_o = (state == DIV_END) ? result_r : '0;
   end

endmodule
